// File: rtl/alu_ctx_sequencer_pkg.sv
// alu_ctx_sequencer_pkg: shared widths, defaults and FSM encoding for the ALU context sequencer
package alu_ctx_sequencer_pkg;
  localparam int ALU_CFG_BITS = 8;
  localparam int CTX_IM_BITS = 16;
  localparam int CTX_DEPTH_DEF = 16;
  localparam int CTX_AW_DEF = 4;
  localparam int FLUSH_CYCLES_DEF = 2;
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_FLUSH = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/alu_ctx_sequencer_ctx_mem.sv
// alu_ctx_sequencer_ctx_mem: context register file, one synchronous write port, one asynchronous read port
//   CLK      clock
//   we       write enable
//   wr_addr  write address
//   wr_data  write word {CFG, IM}
//   rd_addr  read address
//   rd_data  combinational read word
module alu_ctx_sequencer_ctx_mem import alu_ctx_sequencer_pkg::*; #(
  parameter int DEPTH = CTX_DEPTH_DEF,
  parameter int AW = CTX_AW_DEF,
  parameter int W = ALU_CFG_BITS + CTX_IM_BITS
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge CLK)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/alu_ctx_sequencer.sv
// alu_ctx_sequencer: steps a context memory onto the ALU control inputs, then drains and pulses done
//   CLK, RST (async, active-low)
//   wr_en_in/wr_addr_in/wr_data_in  context write port (IDLE only), wr_err_out pulses on a dropped write
//   start_in/abort_in/stall_in      run control
//   ctx_last_in/iter_in             run bounds, latched at start (iter 0 treated as 1)
//   CFG_out/IM_out/En_out/Mode_out/Finish_out  registered ALU controls
//   busy_out/done_out               status
// Optional feature macro CTX_SEQ_LOOP_EN: multi-pass iteration; when undefined iter_in is unused.
module alu_ctx_sequencer import alu_ctx_sequencer_pkg::*; #(
  parameter int CTX_DEPTH = CTX_DEPTH_DEF,
  parameter int CTX_AW = CTX_AW_DEF,
  parameter int CFG_W = ALU_CFG_BITS,
  parameter int IM_W = CTX_IM_BITS,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en_in,
  input  logic [CTX_AW-1:0]     wr_addr_in,
  input  logic [CFG_W+IM_W-1:0] wr_data_in,
  output logic                  wr_err_out,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  stall_in,
  input  logic [CTX_AW-1:0]     ctx_last_in,
  input  logic [7:0]            iter_in,
  output logic [CFG_W-1:0]      CFG_out,
  output logic [IM_W-1:0]       IM_out,
  output logic                  En_out,
  output logic                  Mode_out,
  output logic                  Finish_out,
  output logic                  busy_out,
  output logic                  done_out
);
  seq_state_t state, state_n;
  logic [CTX_AW-1:0] ptr, ptr_n, last, last_n, p, lst;
  logic [7:0] fcnt, fcnt_n;
  logic [CFG_W-1:0] cfg_n;
  logic [IM_W-1:0] im_n;
  logic [CFG_W+IM_W-1:0] rd_data;
  logic en_n, mode_n, fin_n, done_n, err_n, we, step, last_pass;
`ifdef CTX_SEQ_LOOP_EN
  logic [7:0] icnt, icnt_n, iters, iters_n, it, ic;
`else
  logic unused_iter;
  assign unused_iter = ^iter_in;
`endif
  assign err_n = wr_en_in && (state != SEQ_IDLE || start_in);
  assign we = wr_en_in && !err_n;
  assign busy_out = state != SEQ_IDLE;
  alu_ctx_sequencer_ctx_mem #(.DEPTH(CTX_DEPTH), .AW(CTX_AW), .W(CFG_W + IM_W)) u_ctx_mem (
    .CLK(CLK),
    .we(we),
    .wr_addr(wr_addr_in),
    .wr_data(wr_data_in),
    .rd_addr(p),
    .rd_data(rd_data)
  );
  // In IDLE the start cycle itself presents ctx[0], so the step logic works from the fresh bounds.
  always_comb begin
    p = (state == SEQ_IDLE) ? '0 : ptr;
    lst = (state == SEQ_IDLE) ? ctx_last_in : last;
`ifdef CTX_SEQ_LOOP_EN
    it = (state == SEQ_IDLE) ? ((iter_in == 8'd0) ? 8'd1 : iter_in) : iters;
    ic = (state == SEQ_IDLE) ? 8'd0 : icnt;
    last_pass = ic == it - 8'd1;
`else
    last_pass = 1'b1;
`endif
  end
  always_comb begin
    step = (state == SEQ_IDLE && start_in) || (state == SEQ_RUN && !Finish_out && !stall_in);
    state_n = state;
    ptr_n = ptr;
    last_n = last;
    fcnt_n = fcnt;
    cfg_n = CFG_out;
    im_n = IM_out;
    en_n = 1'b0;
    mode_n = Mode_out;
    fin_n = 1'b0;
    done_n = 1'b0;
`ifdef CTX_SEQ_LOOP_EN
    icnt_n = icnt;
    iters_n = iters;
`endif
    case (state)
      SEQ_IDLE: if (start_in) begin
        state_n = SEQ_RUN;
        last_n = ctx_last_in;
`ifdef CTX_SEQ_LOOP_EN
        iters_n = it;
`endif
      end
      // Finish was shown last cycle: the first drain cycle starts now.
      SEQ_RUN: if (Finish_out) begin
        state_n = SEQ_FLUSH;
        fcnt_n = 8'd1;
      end
      SEQ_FLUSH: if (fcnt == 8'(FLUSH_CYCLES)) begin
        state_n = SEQ_DONE;
        done_n = 1'b1;
        mode_n = 1'b0;
        cfg_n = '0;
        im_n = '0;
      end else fcnt_n = fcnt + 8'd1;
      default: begin
        state_n = SEQ_IDLE;
        mode_n = 1'b0;
        cfg_n = '0;
        im_n = '0;
      end
    endcase
    if (step) begin
      en_n = 1'b1;
      mode_n = 1'b1;
      {cfg_n, im_n} = rd_data;
      fin_n = (p == lst) && last_pass;
      ptr_n = (p == lst) ? '0 : p + CTX_AW'(1);
`ifdef CTX_SEQ_LOOP_EN
      icnt_n = (p == lst) ? ic + 8'd1 : ic;
`endif
    end
    if (abort_in && state != SEQ_IDLE) begin
      state_n = SEQ_IDLE;
      ptr_n = '0;
      en_n = 1'b0;
      mode_n = 1'b0;
      fin_n = 1'b0;
      done_n = 1'b0;
      cfg_n = '0;
      im_n = '0;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= SEQ_IDLE;
      ptr <= '0;
      last <= '0;
      fcnt <= '0;
      CFG_out <= '0;
      IM_out <= '0;
      En_out <= 1'b0;
      Mode_out <= 1'b0;
      Finish_out <= 1'b0;
      done_out <= 1'b0;
      wr_err_out <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      last <= last_n;
      fcnt <= fcnt_n;
      CFG_out <= cfg_n;
      IM_out <= im_n;
      En_out <= en_n;
      Mode_out <= mode_n;
      Finish_out <= fin_n;
      done_out <= done_n;
      wr_err_out <= err_n;
    end
`ifdef CTX_SEQ_LOOP_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      icnt <= 8'd0;
      iters <= 8'd0;
    end else begin
      icnt <= icnt_n;
      iters <= iters_n;
    end
`endif
endmodule

// File: tb/tb_alu_ctx_sequencer.sv
// tb_alu_ctx_sequencer: directed table-driven bench for the ALU context sequencer
module tb_alu_ctx_sequencer;
  import alu_ctx_sequencer_pkg::*;
`ifdef CTX_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b0;
  logic wr_en_in = 1'b0, wr_err_out;
  logic [3:0] wr_addr_in = '0;
  logic [23:0] wr_data_in = '0;
  logic start_in = 1'b0, abort_in = 1'b0, stall_in = 1'b0;
  logic [3:0] ctx_last_in = '0;
  logic [7:0] iter_in = '0;
  logic [7:0] CFG_out;
  logic [15:0] IM_out;
  logic En_out, Mode_out, Finish_out, busy_out, done_out;
  int checks = 0, errors = 0;
  alu_ctx_sequencer dut (
    .CLK(CLK), .RST(RST),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_err_out(wr_err_out),
    .start_in(start_in), .abort_in(abort_in), .stall_in(stall_in),
    .ctx_last_in(ctx_last_in), .iter_in(iter_in),
    .CFG_out(CFG_out), .IM_out(IM_out), .En_out(En_out), .Mode_out(Mode_out),
    .Finish_out(Finish_out), .busy_out(busy_out), .done_out(done_out)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    int last;
    int iter;
    int stall_at;
    int stall_len;
    int en_loop;
    int en_single;
    int done_loop;
    int done_single;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [23:0] d, output logic err);
    @(negedge CLK);
    wr_en_in = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    @(negedge CLK);
    wr_en_in = 1'b0;
    err = wr_err_out;
  endtask
  task automatic run_vec(input vec_t v, input int n);
    int en_cnt = 0, fin_cnt = 0, fin_ok = 0, done_cyc = -1, bad = 0, exp_en, exp_done, k;
    logic [7:0] prev = '0;
    exp_en = LOOP ? v.en_loop : v.en_single;
    exp_done = LOOP ? v.done_loop : v.done_single;
    @(negedge CLK);
    ctx_last_in = 4'(v.last);
    iter_in = 8'(v.iter);
    start_in = 1'b1;
    @(negedge CLK);
    start_in = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (En_out) begin
        k = en_cnt % (v.last + 1);
        if (CFG_out != 8'h10 + 8'(k) || IM_out != 16'hA000 + 16'(k)) bad++;
        en_cnt++;
      end else if (!done_out && CFG_out != prev) bad++;
      if (Finish_out) begin
        fin_cnt++;
        if (En_out && en_cnt == exp_en) fin_ok++;
      end
      if (!busy_out) bad++;
      prev = CFG_out;
      stall_in = (c >= v.stall_at && c < v.stall_at + v.stall_len);
      if (done_out) begin
        done_cyc = c;
        if (Mode_out || En_out || CFG_out != 0 || IM_out != 0) bad++;
        break;
      end
      @(negedge CLK);
    end
    stall_in = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d_en_cycles", n), en_cnt, exp_en);
    chk($sformatf("v%0d_done_cycle", n), done_cyc, exp_done);
    chk($sformatf("v%0d_finish_count", n), fin_cnt, 1);
    chk($sformatf("v%0d_finish_on_last", n), fin_ok, 1);
    chk($sformatf("v%0d_sequence_errs", n), bad, 0);
    chk($sformatf("v%0d_idle_after", n), {busy_out, done_out, Mode_out, CFG_out}, 0);
  endtask
  initial begin
    logic err;
    int seen;
    vecs[0] = '{0, 1, 0, 0, 1, 1, 4, 4};
    vecs[1] = '{2, 3, 0, 0, 9, 3, 12, 6};
    vecs[2] = '{3, 1, 2, 2, 4, 4, 9, 9};
    vecs[3] = '{15, 0, 0, 0, 16, 16, 19, 19};
    vecs[4] = '{1, 2, 3, 1, 4, 2, 8, 5};
    #12;
    chk("reset_outs", {En_out, Mode_out, Finish_out, done_out, busy_out, wr_err_out}, 0);
    chk("reset_cfg_im", {CFG_out, IM_out}, 0);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), {8'h10 + 8'(i), 16'hA000 + 16'(i)}, err);
      seen += int'(err);
    end
    chk("idle_write_err", seen, 0);
    wr(4'd0, {8'h05, 16'h0012}, err);
    @(negedge CLK);
    ctx_last_in = 4'd0;
    iter_in = 8'd1;
    start_in = 1'b1;
    @(negedge CLK);
    start_in = 1'b0;
    chk("single_ctrl", {En_out, Finish_out, Mode_out, busy_out}, 4'hF);
    chk("single_cfg_im", {CFG_out, IM_out}, {8'h05, 16'h0012});
    @(negedge CLK);
    chk("single_flush", {En_out, Finish_out, Mode_out, CFG_out}, {3'b001, 8'h05});
    repeat (2) @(negedge CLK);
    chk("single_done", {done_out, Mode_out, busy_out}, 3'b101);
    @(negedge CLK);
    chk("single_busy_low", {busy_out, done_out}, 0);
    wr(4'd0, {8'h10, 16'hA000}, err);
    @(negedge CLK);
    wr_en_in = 1'b1;
    wr_addr_in = 4'd1;
    wr_data_in = 24'hFFFFFF;
    ctx_last_in = 4'd3;
    iter_in = 8'd1;
    start_in = 1'b1;
    @(negedge CLK);
    chk("wr_err_start", {wr_err_out, busy_out, En_out}, 3'b111);
    chk("start_ctx0", CFG_out, 8'h10);
    wr_addr_in = 4'd2;
    @(negedge CLK);
    wr_en_in = 1'b0;
    start_in = 1'b0;
    chk("wr_err_busy", wr_err_out, 1);
    chk("start_ignored_ctx1", {En_out, CFG_out}, {1'b1, 8'h11});
    @(negedge CLK);
    chk("pre_abort_ctx2", {En_out, CFG_out, wr_err_out}, {1'b1, 8'h12, 1'b0});
    abort_in = 1'b1;
    @(negedge CLK);
    abort_in = 1'b0;
    chk("abort_outs", {En_out, Mode_out, Finish_out, done_out, busy_out, CFG_out, IM_out}, 0);
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      seen += int'(done_out) + int'(busy_out);
    end
    chk("abort_no_done", seen, 0);
    @(negedge CLK);
    ctx_last_in = 4'd0;
    iter_in = 8'd1;
    start_in = 1'b1;
    @(negedge CLK);
    start_in = 1'b0;
    @(negedge CLK);
    chk("flush_before_reset", {En_out, Mode_out, busy_out}, 3'b011);
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset_outs", {En_out, Mode_out, Finish_out, done_out, busy_out, CFG_out, IM_out}, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_idle", {busy_out, Mode_out}, 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
